// File: rtl/ram_burst_master.sv
// Bus-master front end for the datapath data RAM: single/burst
// read and write requests are sequenced onto the RAM slave pins.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_rw/addr/len      1=read, start address, beats-1
//   wd_valid/ready/data  write-data stream
//   rd_valid/data/last   registered read-data stream
//   busy                 controller not idle
//   ram_cs/rw/address    RAM control pins
//   ram_data_in/out      RAM data pins
module ram_burst_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_DRAIN,
    WR_BEAT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Read-return tags: one stage per cycle of RAM latency.
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0] pl_q, pl_d;

  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              issue;
  logic              issue_last;
  logic              cs_c;
  logic              rw_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] din_c;
  logic              req_rdy_c;
  logic              wd_rdy_c;
  logic              tag_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      pv_q       <= '0;
      pl_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      pv_q       <= pv_d;
      pl_q       <= pl_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    cs_c       = 1'b0;
    rw_c       = 1'b0;
    addr_c     = '0;
    din_c      = '0;
    req_rdy_c  = 1'b0;
    wd_rdy_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_rdy_c = 1'b1;
        if (req_valid) begin
          ptr_d   = req_addr;
          cnt_d   = req_len;
          state_d = req_rw ? RD_ISSUE : WR_BEAT;
        end
      end
      RD_ISSUE: begin
        cs_c   = 1'b1;
        rw_c   = 1'b1;
        addr_c = ptr_q;
        issue  = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          issue_last = 1'b1;
          state_d    = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        // Last beat on the output now, so the
        // controller frees up next cycle.
        if (rd_valid_q && rd_last_q && ~|pv_q)
          state_d = IDLE;
      end
      WR_BEAT: begin
        wd_rdy_c = 1'b1;
        addr_c   = ptr_q;
        din_c    = wd_data;
        cs_c     = wd_valid;
        if (wd_valid) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pv_d    = '0;
    pl_d    = '0;
    pv_d[0] = issue;
    pl_d[0] = issue_last;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
  end

  // Tag leaving the pipe marks the cycle the RAM
  // presents that beat's data.
  assign tag_out    = pv_q[RD_LAT-1];
  assign rd_valid_d = tag_out;
  assign rd_last_d  = tag_out & pl_q[RD_LAT-1];
  assign rd_data_d  = tag_out ? ram_data_out : rd_data_q;

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;
  assign busy     = (state_q != IDLE);

  assign req_ready   = req_rdy_c & ~rst;
  assign wd_ready    = wd_rdy_c & ~rst;
  assign ram_cs      = cs_c & ~rst;
  assign ram_rw      = rw_c & ~rst;
  assign ram_address = rst ? '0 : addr_c;
  assign ram_data_in = rst ? '0 : din_c;

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Bus-master front end for the 16x16 data RAM in the RISC datapath. Accepts single or burst read/write requests from the core over a valid/ready handshake, sequences the RAM's `cs`/`rw`/`address`/`data_in` pins one beat per cycle, and returns read data as a registered stream. Burst addresses wrap modulo 16. This is the initiator that drives the RAM's slave port.

## Interface
- `ADDR_W`, 4: RAM address width; bursts wrap modulo 2^ADDR_W.
- `DATA_W`, 16: data width.
- `RD_LAT`, 1: RAM read latency, in cycles from the `cs&rw` cycle until `ram_data_out` is valid. Range 1..4.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_rw` in 1: 1 = read, 0 = write (same encoding as RAM `rw`).
- `req_addr` in ADDR_W: start address.
- `req_len` in ADDR_W: beats minus 1 (0 = 1 beat, 15 = 16 beats).
- `wd_valid` in 1: write-data beat present.
- `wd_ready` out 1: write beat consumed this cycle.
- `wd_data` in DATA_W: write data.
- `rd_valid` out 1: read data valid (no backpressure).
- `rd_data` out DATA_W: read data.
- `rd_last` out 1: final beat of the read burst, qualified by `rd_valid`.
- `busy` out 1: state is not IDLE.
- `ram_cs` out 1: RAM chip select.
- `ram_rw` out 1: RAM read/write (1 = read).
- `ram_address` out ADDR_W: RAM address.
- `ram_data_in` out DATA_W: RAM write data.
- `ram_data_out` in DATA_W: RAM read data.

## Operation
- **FSM states:** IDLE, RD_ISSUE, RD_DRAIN, WR_BEAT.
- **IDLE:** `req_ready = 1` when `rst = 0`.
  - On `req_valid & req_ready`, latch `req_addr` into the address pointer `ptr` and `req_len` into the beat counter `cnt`.
  - Go to RD_ISSUE if `req_rw = 1`, else WR_BEAT.
- **RD_ISSUE:** one read issued every cycle.
  - Drive `ram_cs = 1`, `ram_rw = 1`, `ram_address = ptr`.
  - Each cycle: `ptr <= ptr + 1` (mod 2^ADDR_W) and `cnt <= cnt - 1`.
  - When `cnt == 0`, the issue is the last beat: tag it last and go to RD_DRAIN.
- **Read return pipeline:** an RD_LAT-deep shift register of {valid, last} tags.
  - When a tag exits the pipeline, `ram_data_out` is captured into `rd_data` and `rd_valid`/`rd_last` are set for one cycle.
- **RD_DRAIN:** `ram_cs = 0`. When the pipeline is empty and the last beat has been delivered, go to IDLE.
- **WR_BEAT:** `wd_ready = 1`, `ram_rw = 0`, `ram_address = ptr`, `ram_data_in = wd_data`, `ram_cs = wd_valid`.
  - On `wd_valid = 1`: `ptr` increments, `cnt` decrements. If `cnt == 0`, go to IDLE.
  - On `wd_valid = 0`: stall. No RAM access; `ptr` and `cnt` hold.
- **RAM outputs:** `ram_*` are combinational from registered state and `wd_*`, and are forced to 0 while `rst = 1`.
- **Reset values:**
  - Control: state IDLE, `req_ready = 0` while `rst` is high, `wd_ready = 0`, `rd_valid = 0`, `rd_last = 0`, `busy = 0`.
  - Datapath: `rd_data = 0`, `ptr = 0`, `cnt = 0`, pipeline tags cleared, all `ram_*` = 0.
- **Reset mid-burst:** abort immediately. In-flight read tags are discarded and no `rd_valid` appears after reset. Write beats not yet accepted are never written.
- **New requests:** ignored (`req_ready = 0`) in any non-IDLE state. There is no queuing.
- **Wrap-around:** a burst from address 14 with `req_len = 3` accesses 14, 15, 0, 1.

## Timing
- Request accepted at edge E. The first RAM access is in the cycle after E.
- **Read latency:** the beat issued in cycle n gives `rd_valid` in cycle n + RD_LAT + 1, with `rd_data` registered.
  - With RD_LAT = 1, a read burst of L+1 beats asserts `rd_valid` for L+1 consecutive cycles, starting 3 cycles after the accept cycle.
  - `busy` falls, and `req_ready` rises, in the cycle after `rd_last`.
- **Write:** a beat with `wd_valid = 1` in cycle n is written by the RAM at the end of cycle n.
  - After the final beat, the FSM is IDLE (`req_ready = 1`) the next cycle.
  - Minimum write burst time: L+1 cycles.
- **Read-after-write:** a read request accepted the cycle after a write ends returns the new data, because RAM writes commit before the read issue.
- **Back-to-back requests:** with `req_valid` held high, minimum request spacing is:
  - Read: L+1 + RD_LAT + 2 cycles.
  - Write: L+2 cycles.

## Test plan
- **Single read:**
  - Stimulus: assert `rst` for 2 cycles (RAM initializes), then read with `req_addr = 6`, `req_len = 0`.
  - Response: one `rd_valid` with `rd_data = 0x0032` and `rd_last = 1`, 3 cycles after accept; `busy` then drops.
- **Wrapping burst read:**
  - Stimulus: `req_addr = 14`, `req_len = 3`.
  - Response: `ram_address` sequence 14, 15, 0, 1; `rd_data` sequence 0x0094, 0x0105, 0x0001, 0x0002 on consecutive cycles; `rd_last` only on 0x0002.
- **Write burst with stalls, then readback:**
  - Stimulus: write `req_addr = 2`, `req_len = 1`, with `wd_data` 0xAAAA, then a 2-cycle `wd_valid` gap, then 0x5555. Then read addr 2, `len = 1`.
  - Response: `ram_cs` low during the gap; readback 0xAAAA, 0x5555.
- **Handshake exclusion:**
  - Stimulus: hold `req_valid = 1` during a 16-beat read from address 0.
  - Response: `req_ready = 0` throughout; the second request is accepted only after `rd_last` plus 1 cycle; exactly 16 `rd_valid` pulses for the first burst.
- **Reset mid-burst:**
  - Stimulus: assert `rst` 2 cycles into an 8-beat read.
  - Response: the next cycle has `rd_valid = 0`, `ram_cs = 0`, and `busy = 0`; no further `rd_valid`; a subsequent read of addr 7 returns 0x0050.
- **Read-after-write:**
  - Stimulus: write 0x1234 to addr 15, then immediately read addr 15.
  - Response: `rd_data = 0x1234`.
